// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arb_pkg
//  Description : Shared widths, write-record type and source-select encoding
//                for the register-file write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // One register-file write: destination register and data.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LD   = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_WB   = 2'd3
    } rf_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_fifo
//  Description : DEPTH-entry FIFO of deferred core writes. Besides push/pop it
//                exposes every slot's rd and a per-slot valid flag so the
//                arbiter can compare source registers against queued writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = rf_arb_pkg::AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  rf_arb_pkg::rf_wr_t       i_push_data,
    input  logic                     i_pop,
    output rf_arb_pkg::rf_wr_t       o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [DEPTH*AW-1:0]      o_entry_rd,
    output logic [DEPTH-1:0]         o_entry_valid
);
    import rf_arb_pkg::*;

    localparam int c_PW = $clog2(DEPTH);

    rf_wr_t            r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only observed while it is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // A slot is valid when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [c_PW-1:0] w_off;
        assign w_off               = c_PW'(i) - r_rd_ptr;
        assign o_entry_valid[i]    = ({1'b0, w_off} < r_count);
        assign o_entry_rd[i*AW +: AW] = r_mem[i].rd;
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Owns the single register-file write port. Load returns win,
//                then buffered core writes, then a live core writeback. A
//                load scoreboard plus queued/in-flight writes feed a RAW/WAW
//                hazard that, with FIFO-full, forms the core stall.
//                Optional macro RF_ARB_STATS_EN adds conflict_cnt, counting
//                cycles in which a core write had to be deferred.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = rf_arb_pkg::XLEN,
    parameter int AW    = rf_arb_pkg::AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rf_write_en,
    output logic [AW-1:0]   rf_write_register,
    output logic [XLEN-1:0] rf_write_data,
    output logic            Stall
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]     conflict_cnt
`endif
);
    import rf_arb_pkg::*;

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_NREG = 2 ** AW;

    logic                  w_wb_live;
    logic                  w_ld_live;
    rf_src_e               w_sel;
    rf_wr_t                w_wr_next;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    rf_wr_t                w_fifo_head;
    logic [c_CW-1:0]       w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DEPTH*AW-1:0]   w_entry_rd;
    logic [DEPTH-1:0]      w_entry_valid;
    logic [c_NREG-1:0]     r_pending;
    logic [c_NREG-1:0]     w_pending_next;
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;
    logic                  w_waw;

    // Writes to x0 are architecturally meaningless and are filtered here.
    assign w_wb_live = wb_valid && (wb_rd != '0);
    assign w_ld_live = ld_valid && (ld_rd != '0);

    // Priority select: load return, then FIFO head, then live writeback.
    always_comb begin
        w_sel     = SRC_NONE;
        w_wr_next = '0;
        if (w_ld_live) begin
            w_sel          = SRC_LD;
            w_wr_next.rd   = ld_rd;
            w_wr_next.data = ld_data;
        end else if (!w_fifo_empty) begin
            w_sel     = SRC_FIFO;
            w_wr_next = w_fifo_head;
        end else if (w_wb_live) begin
            w_sel          = SRC_WB;
            w_wr_next.rd   = wb_rd;
            w_wr_next.data = wb_data;
        end
    end

    // A live writeback that loses arbitration is queued to keep core order.
    assign w_fifo_push = w_wb_live && (w_sel != SRC_WB) && !w_fifo_full;
    assign w_fifo_pop  = (w_sel == SRC_FIFO);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_fifo_push),
        .i_push_data   ({wb_rd, wb_data}),
        .i_pop         (w_fifo_pop),
        .o_head        (w_fifo_head),
        .o_count       (w_fifo_count),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_entry_rd    (w_entry_rd),
        .o_entry_valid (w_entry_valid)
    );

    // Registered write port toward the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_write_en       <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            rf_write_en       <= (w_sel != SRC_NONE);
            rf_write_register <= w_wr_next.rd;
            rf_write_data     <= w_wr_next.data;
        end
    end

    // Scoreboard update: clear on return first so a same-rd issue stays set.
    always_comb begin
        w_pending_next = r_pending;
        if (w_ld_live) w_pending_next[ld_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0)) w_pending_next[ld_issue_rd] = 1'b1;
    end

    // Outstanding-load scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pending <= '0;
        else        r_pending <= w_pending_next;
    end

    // RAW check of both sources against scoreboard, queue and output stage.
    always_comb begin
        w_rs1_hit = (rs1 != '0) &&
                    (r_pending[rs1] || (rf_write_en && (rf_write_register == rs1)));
        w_rs2_hit = (rs2 != '0) &&
                    (r_pending[rs2] || (rf_write_en && (rf_write_register == rs2)));
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && (rs1 != '0) && (w_entry_rd[i*AW +: AW] == rs1))
                w_rs1_hit = 1'b1;
            if (w_entry_valid[i] && (rs2 != '0) && (w_entry_rd[i*AW +: AW] == rs2))
                w_rs2_hit = 1'b1;
        end
    end

    // A core write to a register with a load in flight would be overwritten late.
    assign w_waw = w_wb_live && r_pending[wb_rd];

    assign Stall = w_rs1_hit || w_rs2_hit || w_waw ||
                   (w_fifo_count == c_CW'(DEPTH));

`ifdef RF_ARB_STATS_EN
    // Saturating count of cycles in which a core write was deferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            conflict_cnt <= '0;
        else if (w_fifo_push && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif

    // The core must honour Stall; a writeback into a full queue is lost.
    a_no_wb_when_full : assert property (
        @(posedge clk) disable iff (!reset) !(w_wb_live && w_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Directed self-checking bench for rf_wb_arbiter (DEPTH=4).
//                Covers RF_ARB_STATS_EN when the macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rf_write_en;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic        Stall;
`ifdef RF_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .ld_issue          (ld_issue),
        .ld_issue_rd       (ld_issue_rd),
        .ld_valid          (ld_valid),
        .ld_rd             (ld_rd),
        .ld_data           (ld_data),
        .rs1               (rs1),
        .rs2               (rs2),
        .rf_write_en       (rf_write_en),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .Stall             (Stall)
`ifdef RF_ARB_STATS_EN
        ,
        .conflict_cnt      (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid    = 1'b0; wb_rd = '0; wb_data = '0;
        ld_issue    = 1'b0; ld_issue_rd = '0;
        ld_valid    = 1'b0; ld_rd = '0; ld_data = '0;
        rs1         = '0;   rs2 = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_en",    32'(rf_write_en), 32'd0);
        chk("rst_reg",   32'(rf_write_register), 32'd0);
        chk("rst_data",  rf_write_data, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_count", 32'(dut.w_fifo_count), 32'd0);
        reset = 1'b1;
        tick();

        // Live-only write
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_A5A5;
        #1 chk("live_stall", 32'(Stall), 32'd0);
        tick();
        idle();
        chk("live_en",   32'(rf_write_en), 32'd1);
        chk("live_reg",  32'(rf_write_register), 32'd5);
        chk("live_data", rf_write_data, 32'hA5A5_A5A5);
        tick();
        chk("live_en_off", 32'(rf_write_en), 32'd0);

        // x0 drop
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        tick();
        idle();
        chk("x0_en",    32'(rf_write_en), 32'd0);
        chk("x0_count", 32'(dut.w_fifo_count), 32'd0);
        tick();
        chk("x0_en2",   32'(rf_write_en), 32'd0);

        // Return / writeback collision
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h22;
        tick();
        idle();
        chk("col1_en",    32'(rf_write_en), 32'd1);
        chk("col1_reg",   32'(rf_write_register), 32'd3);
        chk("col1_data",  rf_write_data, 32'h11);
        chk("col1_count", 32'(dut.w_fifo_count), 32'd1);
        rs1 = 5'd4;
        #1 chk("col_fifo_raw", 32'(Stall), 32'd1);
        rs1 = 5'd0;
        #1 chk("col_no_raw", 32'(Stall), 32'd0);
        tick();
        chk("col2_en",    32'(rf_write_en), 32'd1);
        chk("col2_reg",   32'(rf_write_register), 32'd4);
        chk("col2_data",  rf_write_data, 32'h22);
        chk("col2_count", 32'(dut.w_fifo_count), 32'd0);
`ifdef RF_ARB_STATS_EN
        chk("col_conflict_cnt", 32'(conflict_cnt), 32'd1);
`endif
        tick();
        chk("col3_en", 32'(rf_write_en), 32'd0);

        // Scoreboard RAW and WAW
        ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7;
        #1 chk("raw_pre_issue", 32'(Stall), 32'd0);
        tick();
        ld_issue = 1'b0;
        #1 chk("raw_pending", 32'(Stall), 32'd1);
        tick();
        chk("raw_pending2", 32'(Stall), 32'd1);
        rs1 = 5'd0; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h99;
        #1 chk("waw_stall", 32'(Stall), 32'd1);
        wb_valid = 1'b0; wb_rd = 5'd0; rs1 = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        #1 chk("raw_on_return", 32'(Stall), 32'd1);
        tick();
        ld_valid = 1'b0; ld_rd = 5'd0;
        chk("raw_out_en",   32'(rf_write_en), 32'd1);
        chk("raw_out_reg",  32'(rf_write_register), 32'd7);
        chk("raw_out_data", rf_write_data, 32'h77);
        #1 chk("raw_out_stage", 32'(Stall), 32'd1);
        tick();
        chk("raw_done_en",    32'(rf_write_en), 32'd0);
        chk("raw_done_stall", 32'(Stall), 32'd0);
        idle();

        // FIFO fill behind four (unexpected) load returns
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1; ld_rd = 5'(20 + k); ld_data = 32'h100 + 32'(k);
            wb_valid = 1'b1; wb_rd = 5'(8 + k);  wb_data = 32'h200 + 32'(k);
            #1 chk("full_fill_stall", 32'(Stall), 32'd0);
            tick();
            chk("full_ld_reg",  32'(rf_write_register), 32'(20 + k));
            chk("full_ld_data", rf_write_data, 32'h100 + 32'(k));
        end
        idle();
        #1 chk("full_count", 32'(dut.w_fifo_count), 32'd4);
        chk("full_stall", 32'(Stall), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_en",    32'(rf_write_en), 32'd1);
            chk("drain_reg",   32'(rf_write_register), 32'(8 + k));
            chk("drain_data",  rf_write_data, 32'h200 + 32'(k));
            chk("drain_count", 32'(dut.w_fifo_count), 32'(3 - k));
            chk("drain_stall", 32'(Stall), 32'd0);
        end
        tick();
        chk("drain_idle_en", 32'(rf_write_en), 32'd0);

        // Reset with two queued writes
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h300;
        wb_valid = 1'b1; wb_rd = 5'd9;  wb_data = 32'h309;
        tick();
        ld_rd = 5'd21; ld_data = 32'h301;
        wb_rd = 5'd10; wb_data = 32'h30A;
        tick();
        idle();
        chk("mid_count", 32'(dut.w_fifo_count), 32'd2);
        reset = 1'b0;
        #1 chk("mid_async_en",    32'(rf_write_en), 32'd0);
        chk("mid_async_count", 32'(dut.w_fifo_count), 32'd0);
        tick();
        chk("mid_rst_en",    32'(rf_write_en), 32'd0);
        chk("mid_rst_stall", 32'(Stall), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_en", 32'(rf_write_en), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
